clk_div_param: RTL
==================

CLK_DIV_PARAM -- requirements
Module: clk_div_param

Interface
REQ-001 Parameter WIDTH, default 7, counter and divisor width in bits (2..32).
REQ-002 Parameter DEFAULT_DIV, default 101, divisor loaded at reset; SHALL be < 2^WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable; low = freeze all state except load/reset effects.
REQ-006 mode  input  1  0 = free-run, 1 = one-shot.
REQ-007 load  input  1  one-cycle strobe; captures div_in and restarts the period.
REQ-008 div_in  input  WIDTH  new divisor D, sampled only when load=1.
REQ-009 tick  output  WIDTH-independent 1  registered single-cycle pulse at each period end.
REQ-010 cycle  output  1  registered square wave; toggles on every tick.
REQ-011 done  output  1  registered; one-shot period completed.
REQ-012 count  output  WIDTH  current counter value, registered.

Function
REQ-013 Internal divisor register div_reg (WIDTH bits) SHALL define period D = div_reg clock cycles between ticks.
REQ-014 Active state = en=1, div_reg!=0, and not (mode=1 and done=1).
REQ-015 Active and count != D-1: count SHALL increment by 1, tick SHALL be 0.
REQ-016 Active and count == D-1: count SHALL wrap to 0, tick SHALL be 1 for exactly the next cycle, cycle SHALL invert.
REQ-017 Active and count == D-1 with mode=1: done SHALL be set to 1 at the same edge as tick.
REQ-018 Not active: count, cycle, done SHALL hold; tick SHALL be 0.
REQ-019 D=1: tick SHALL be 1 every cycle while active; cycle toggles every cycle.
REQ-020 D=0: block SHALL stop (count held at 0 after load, no ticks); no error flag.
REQ-021 load=1 (any en): div_reg <= div_in, count <= 0, done <= 0, tick <= 0; cycle holds.
REQ-022 load has priority over counting in the same cycle; no tick SHALL be produced at a load edge even if count == D-1.
REQ-023 mode 1->0 while done=1: done SHALL clear at the next edge and counting SHALL resume from count=0.
REQ-024 mode 0->1 mid-period: current period SHALL complete normally and set done at its tick.
REQ-025 Latency: with en=1 from rst release and D constant, tick SHALL be high in the cycles after rising edges D, 2D, 3D ... (edge 1 = first edge with rst=0).
REQ-026 Counter arithmetic SHALL be modulo D, never exceeding D-1; no WIDTH overflow path exists.

Reset
REQ-027 rst=1 SHALL set count=0, tick=0, cycle=0, done=0, div_reg=DEFAULT_DIV at the next edge.
REQ-028 rst SHALL override load, en and mode in the same cycle.
REQ-029 rst asserted mid-period SHALL discard the partial period; the next tick SHALL follow REQ-025 timing from release.

Verification
REQ-030 Defaults, en=1 held, mode=0 -> tick at edges 101, 202, 303; cycle 0->1->0->1 at those edges; count never >100.
REQ-031 load div_in=4 at edge 10, en=1 -> count 0 after edge 10; ticks after edges 14, 18, 22; none at edge 10.
REQ-032 D=5, mode=1, en=1 -> single tick and done=1 after edge 5; count holds 0, no ticks for 20 further cycles; load D=5 -> done=0, next tick 5 edges later.
REQ-033 D=3, en toggled low for 4 cycles at count=1 -> count holds 1, tick 0; after en=1, tick occurs 2 edges later (total elapsed 3 active edges).
REQ-034 D=1 -> tick high every cycle, cycle alternates each cycle; then load D=0 -> tick 0, count 0, cycle frozen.
REQ-035 D=6, rst pulsed at count=4 together with load div_in=2 -> after rst: div_reg=101, count=0, cycle=0, next tick after edge 101 from release.

Source files
------------

// File: rtl/clk_div_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk_div_param                                              |
// | Description : Programmable clock divider / period timer. A WIDTH-bit     |
// |               counter runs modulo the divisor register and emits a       |
// |               single-cycle tick at each period end. It also drives a     |
// |               square wave that toggles on every tick. In one-shot mode   |
// |               the counter stops after the first period and raises done.  |
// |                                                                          |
// | Ports       : clk    - clock, rising edge                                |
// |               rst    - synchronous active-high reset                     |
// |               en     - count enable                                      |
// |               mode   - 0 free-run, 1 one-shot                            |
// |               load   - strobe: capture div_in, restart period            |
// |               div_in - new divisor (WIDTH bits)                          |
// |               tick   - registered one-cycle pulse at period end          |
// |               cycle  - registered square wave, toggles on each tick      |
// |               done   - registered one-shot completion flag               |
// |               count  - registered counter value                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module clk_div_param #(
    parameter int WIDTH       = 7,
    parameter int DEFAULT_DIV = 101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick,
    output logic             cycle,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO    = '0;
    localparam logic [WIDTH-1:0] c_RST_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_cycle;
    logic             r_done;

    logic             w_active;
    logic             w_wrap;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tick_nxt;
    logic             w_cycle_nxt;
    logic             w_done_nxt;

    // A zero divisor parks the block; a finished one-shot stays parked
    // until it is reloaded or switched back to free-run.
    assign w_active = en && (r_div != c_ZERO) && !(mode && r_done);

    // Only meaningful while active, so r_div is non-zero and D-1 cannot
    // underflow; the counter therefore never exceeds D-1.
    assign w_wrap = (r_count == (r_div - c_ONE));

    always_comb begin
        w_div_nxt   = r_div;
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;
        w_cycle_nxt = r_cycle;
        w_done_nxt  = r_done;
        if (load) begin
            // Load wins over counting: the period restarts with no tick,
            // and the square wave keeps its phase.
            w_div_nxt   = div_in;
            w_count_nxt = c_ZERO;
            w_done_nxt  = 1'b0;
        end else if (w_active) begin
            if (w_wrap) begin
                w_count_nxt = c_ZERO;
                w_tick_nxt  = 1'b1;
                w_cycle_nxt = ~r_cycle;
                w_done_nxt  = mode;
            end else begin
                w_count_nxt = r_count + c_ONE;
                // Active mid-period implies done is already low in one-shot;
                // in free-run this clears a done left over from one-shot.
                w_done_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= c_RST_DIV;
            r_count <= c_ZERO;
            r_tick  <= 1'b0;
            r_cycle <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_div   <= w_div_nxt;
            r_count <= w_count_nxt;
            r_tick  <= w_tick_nxt;
            r_cycle <= w_cycle_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign tick  = r_tick;
    assign cycle = r_cycle;
    assign done  = r_done;
    assign count = r_count;

endmodule
`default_nettype wire
